// File: rtl/preg_seq.sv
// Four-state issue sequencer for the picoMIPS register file: READ operands,
// EXEC in a small ALU, write the result back in WB, then pulse done.
module preg_seq #(
    parameter  int DATA_WIDTH  = 8,
    parameter  int ADDR_WIDTH  = 5,
    localparam int INSTR_WIDTH = 4 + 3 * ADDR_WIDTH + DATA_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [INSTR_WIDTH-1:0] instr,
    input  logic                   instr_valid,
    output logic                   instr_ready,
    output logic [ADDR_WIDTH-1:0]  Rd,
    output logic [ADDR_WIDTH-1:0]  Rs,
    output logic [ADDR_WIDTH-1:0]  Rt,
    output logic [1:0]             ctrl,
    output logic [DATA_WIDTH-1:0]  Wdata,
    input  logic [DATA_WIDTH-1:0]  Rd_data,
    input  logic [DATA_WIDTH-1:0]  Rs_data,
    output logic                   done,
    output logic                   zero,
    output logic                   carry,
    output logic                   illegal
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_EXEC = 2'd2;
    localparam logic [1:0] S_WB   = 2'd3;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_ADDI = 4'd6;
    localparam logic [3:0] OP_LDI  = 4'd7;
    localparam logic [3:0] OP_MOV  = 4'd8;

    logic [1:0]            state;
    logic [3:0]            op_q;
    logic [ADDR_WIDTH-1:0] rd_q;
    logic [DATA_WIDTH-1:0] imm_q;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;

    logic                  uses_rt;
    logic                  writes;
    logic                  legal;
    logic [DATA_WIDTH-1:0] alu_res;
    logic                  alu_cy;
    logic [DATA_WIDTH:0]   wide;

    // The extra top bit of the widened sum/difference is the carry (or borrow).
    function automatic logic [DATA_WIDTH:0] add_c(input logic [DATA_WIDTH-1:0] a,
                                                  input logic [DATA_WIDTH-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    function automatic logic [DATA_WIDTH:0] sub_b(input logic [DATA_WIDTH-1:0] a,
                                                  input logic [DATA_WIDTH-1:0] b);
        return {1'b0, a} - {1'b0, b};
    endfunction

    always_comb begin
        uses_rt = (op_q >= OP_ADD) && (op_q <= OP_XOR);
        writes  = (op_q >= OP_ADD) && (op_q <= OP_MOV);
        legal   = (op_q <= OP_MOV);
    end

    always_comb begin
        wide    = '0;
        alu_res = '0;
        alu_cy  = 1'b0;
        case (op_q)
            OP_ADD: begin
                wide    = add_c(op_a, op_b);
                alu_res = wide[DATA_WIDTH-1:0];
                alu_cy  = wide[DATA_WIDTH];
            end
            OP_SUB: begin
                wide    = sub_b(op_a, op_b);
                alu_res = wide[DATA_WIDTH-1:0];
                alu_cy  = wide[DATA_WIDTH];
            end
            OP_ADDI: begin
                wide    = add_c(op_a, imm_q);
                alu_res = wide[DATA_WIDTH-1:0];
                alu_cy  = wide[DATA_WIDTH];
            end
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_LDI:  alu_res = imm_q;
            OP_MOV:  alu_res = op_a;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        ctrl = 2'b00;
        case (state)
            S_READ:  ctrl = {uses_rt, 1'b0};
            S_WB:    ctrl = {1'b0, writes};
            default: ctrl = 2'b00;
        endcase
    end

    assign instr_ready = (state == S_IDLE);
    assign done        = (state == S_WB);

    // Control, visible outputs and flags; reset also aborts an in-flight instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            Rd      <= '0;
            Rs      <= '0;
            Rt      <= '0;
            Wdata   <= '0;
            zero    <= 1'b0;
            carry   <= 1'b0;
            illegal <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        Rd    <= instr[3*ADDR_WIDTH+DATA_WIDTH-1 -: ADDR_WIDTH];
                        Rs    <= instr[2*ADDR_WIDTH+DATA_WIDTH-1 -: ADDR_WIDTH];
                        Rt    <= instr[ADDR_WIDTH+DATA_WIDTH-1 -: ADDR_WIDTH];
                        state <= S_READ;
                    end
                end
                S_READ: state <= S_EXEC;
                S_EXEC: begin
                    if (writes) begin
                        Wdata <= alu_res;
                        zero  <= (alu_res == '0);
                        carry <= alu_cy;
                    end
                    if (!legal) illegal <= 1'b1;
                    state <= S_WB;
                end
                default: begin
                    Rd    <= rd_q;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Datapath capture: instruction fields at handshake, operands at the end of READ.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && instr_valid) begin
            op_q  <= instr[INSTR_WIDTH-1 -: 4];
            rd_q  <= instr[3*ADDR_WIDTH+DATA_WIDTH-1 -: ADDR_WIDTH];
            imm_q <= instr[DATA_WIDTH-1:0];
        end
        if (state == S_READ) begin
            op_a <= Rs_data;
            op_b <= Rd_data;
        end
    end

endmodule

// File: tb/tb_preg_seq.sv
// Directed bench for preg_seq with a behavioural register file on the far side
// of the Rd/Rs/Rt/ctrl interface.
module tb_preg_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic [26:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [4:0]  Rd, Rs, Rt;
    logic [1:0]  ctrl;
    logic [7:0]  Wdata, Rd_data, Rs_data;
    logic        done, zero, carry, illegal;

    preg_seq dut (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .Rd(Rd), .Rs(Rs), .Rt(Rt), .ctrl(ctrl),
        .Wdata(Wdata), .Rd_data(Rd_data), .Rs_data(Rs_data), .done(done),
        .zero(zero), .carry(carry), .illegal(illegal)
    );

    always #5 clk = ~clk;

    logic [7:0] rf [32];
    logic       pl_en = 1'b0;
    logic [4:0] pl_addr = '0;
    logic [7:0] pl_data = '0;
    int         wr_cnt = 0;
    int         done_cnt = 0;

    assign Rs_data = rf[Rs];
    assign Rd_data = ctrl[1] ? rf[Rt] : rf[Rd];

    always @(posedge clk) begin
        if (ctrl[0]) begin
            rf[Rd] <= Wdata;
            wr_cnt <= wr_cnt + 1;
        end else if (pl_en) begin
            rf[pl_addr] <= pl_data;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic preload(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    typedef struct {
        logic [3:0] op;
        logic [4:0] rd, rs, rt;
        logic [7:0] imm;
        bit         pre;
        logic [7:0] a, b;
        bit         we;
        logic [7:0] res;
        bit         rtu;
        bit         z, c, ill;
    } vec_t;

    vec_t vecs [14];

    logic       o_rdy_hs, o_done_wb, o_rdy_after;
    logic [1:0] o_ctrl_rd, o_ctrl_ex, o_ctrl_wb;
    logic [4:0] o_rs_rd, o_rt_rd, o_rd_wb;
    logic [7:0] o_wdata;

    // Fixed 4-cycle walk: IDLE (handshake), READ, EXEC, WB, then sample back in IDLE.
    task automatic run_instr(input logic [26:0] w);
        @(negedge clk);
        instr = w; instr_valid = 1'b1;
        o_rdy_hs = instr_ready;
        @(negedge clk);
        instr_valid = 1'b0;
        o_ctrl_rd = ctrl; o_rs_rd = Rs; o_rt_rd = Rt;
        @(negedge clk);
        o_ctrl_ex = ctrl;
        @(negedge clk);
        o_ctrl_wb = ctrl; o_rd_wb = Rd; o_wdata = Wdata; o_done_wb = done;
        @(negedge clk);
        o_rdy_after = instr_ready;
    endtask

    initial begin
        int         w0, d0;
        int         hs[$];
        int         wes[$];
        int         rdy_cnt;
        int         idx;
        logic [26:0] bl [3];
        string      t;

        reset = 1'b1; instr = '0; instr_valid = 1'b0;
        for (int i = 0; i < 32; i++) preload(5'(i), 8'h00);
        chk("rst_ready",   32'(instr_ready), 32'd1);
        chk("rst_ctrl",    32'(ctrl),        32'd0);
        chk("rst_Rd",      32'(Rd),          32'd0);
        chk("rst_Rs",      32'(Rs),          32'd0);
        chk("rst_Rt",      32'(Rt),          32'd0);
        chk("rst_Wdata",   32'(Wdata),       32'd0);
        chk("rst_flags",   32'({done, zero, carry, illegal}), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        //           op     rd     rs     rt     imm    pre a      b      we res    rtu z  c  ill
        vecs[0]  = '{4'h1, 5'd4,  5'd1,  5'd2,  8'h00, 1, 8'h05, 8'h03, 1, 8'h08, 1, 0, 0, 0};
        vecs[1]  = '{4'h6, 5'd1,  5'd1,  5'd0,  8'h20, 1, 8'hF0, 8'h00, 1, 8'h10, 0, 0, 1, 0};
        vecs[2]  = '{4'h2, 5'd5,  5'd2,  5'd2,  8'h00, 1, 8'h03, 8'h03, 1, 8'h00, 1, 1, 0, 0};
        vecs[3]  = '{4'h2, 5'd6,  5'd3,  5'd8,  8'h00, 1, 8'h02, 8'h05, 1, 8'hFD, 1, 0, 1, 0};
        vecs[4]  = '{4'h3, 5'd7,  5'd3,  5'd8,  8'h00, 1, 8'hF0, 8'h3C, 1, 8'h30, 1, 0, 0, 0};
        vecs[5]  = '{4'h4, 5'd11, 5'd12, 5'd13, 8'h00, 1, 8'h0F, 8'hF0, 1, 8'hFF, 1, 0, 0, 0};
        vecs[6]  = '{4'h5, 5'd14, 5'd15, 5'd16, 8'h00, 1, 8'hAA, 8'hAA, 1, 8'h00, 1, 1, 0, 0};
        vecs[7]  = '{4'h1, 5'd3,  5'd3,  5'd3,  8'h00, 1, 8'h21, 8'h21, 1, 8'h42, 1, 0, 0, 0};
        vecs[8]  = '{4'h7, 5'd0,  5'd0,  5'd0,  8'h77, 0, 8'h00, 8'h00, 1, 8'h77, 0, 0, 0, 0};
        vecs[9]  = '{4'h1, 5'd17, 5'd18, 5'd19, 8'h00, 1, 8'h80, 8'h80, 1, 8'h00, 1, 1, 1, 0};
        vecs[10] = '{4'hC, 5'd23, 5'd24, 5'd25, 8'h00, 0, 8'h00, 8'h00, 0, 8'h00, 0, 1, 1, 1};
        vecs[11] = '{4'h0, 5'd26, 5'd27, 5'd28, 8'h00, 0, 8'h00, 8'h00, 0, 8'h00, 0, 1, 1, 1};
        vecs[12] = '{4'h7, 5'd9,  5'd0,  5'd0,  8'h5A, 0, 8'h00, 8'h00, 1, 8'h5A, 0, 0, 0, 1};
        vecs[13] = '{4'h8, 5'd10, 5'd9,  5'd29, 8'h00, 0, 8'h00, 8'h00, 1, 8'h5A, 0, 0, 0, 1};

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].pre) begin
                preload(vecs[i].rs, vecs[i].a);
                preload(vecs[i].rt, vecs[i].b);
            end
            w0 = wr_cnt; d0 = done_cnt;
            run_instr({vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].rt, vecs[i].imm});
            t = $sformatf("v%0d_", i);
            chk({t, "ready_hs"},  32'(o_rdy_hs),  32'd1);
            chk({t, "ctrl_read"}, 32'(o_ctrl_rd), 32'({vecs[i].rtu, 1'b0}));
            chk({t, "Rs_read"},   32'(o_rs_rd),   32'(vecs[i].rs));
            chk({t, "Rt_read"},   32'(o_rt_rd),   32'(vecs[i].rt));
            chk({t, "ctrl_exec"}, 32'(o_ctrl_ex), 32'd0);
            chk({t, "ctrl_wb"},   32'(o_ctrl_wb), 32'({1'b0, vecs[i].we}));
            chk({t, "Rd_wb"},     32'(o_rd_wb),   32'(vecs[i].rd));
            chk({t, "done_wb"},   32'(o_done_wb), 32'd1);
            chk({t, "done_cnt"},  32'(done_cnt - d0), 32'd1);
            chk({t, "writes"},    32'(wr_cnt - w0),   32'(vecs[i].we));
            if (vecs[i].we) begin
                chk({t, "Wdata"},  32'(o_wdata),         32'(vecs[i].res));
                chk({t, "rf_rd"},  32'(rf[vecs[i].rd]),  32'(vecs[i].res));
            end
            chk({t, "zero"},      32'(zero),        32'(vecs[i].z));
            chk({t, "carry"},     32'(carry),       32'(vecs[i].c));
            chk({t, "illegal"},   32'(illegal),     32'(vecs[i].ill));
            chk({t, "ready_end"}, 32'(o_rdy_after), 32'd1);
        end

        // Back-to-back: valid held high, each word presented until accepted.
        bl[0] = {4'h7, 5'd20, 5'd0,  5'd0,  8'h11};
        bl[1] = {4'h7, 5'd21, 5'd0,  5'd0,  8'h22};
        bl[2] = {4'h1, 5'd22, 5'd20, 5'd21, 8'h00};
        idx = 0; rdy_cnt = 0; w0 = wr_cnt;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge clk);
            if (ctrl[0]) wes.push_back(cyc);
            if (cyc < 12 && instr_ready) rdy_cnt++;
            if (idx < 3) begin
                instr = bl[idx]; instr_valid = 1'b1;
                if (instr_ready) begin
                    hs.push_back(cyc);
                    idx++;
                end
            end else begin
                instr_valid = 1'b0;
            end
        end
        chk("b2b_hs_count", 32'(hs.size()),  32'd3);
        chk("b2b_wr_count", 32'(wes.size()), 32'd3);
        chk("b2b_writes",   32'(wr_cnt - w0), 32'd3);
        chk("b2b_ready_cnt", 32'(rdy_cnt),   32'd3);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("b2b_hs%0d", k),  32'((hs.size()  > k) ? hs[k]  : -1), 32'(4 * k));
            chk($sformatf("b2b_wr%0d", k),  32'((wes.size() > k) ? wes[k] : -1), 32'(4 * k + 3));
        end
        chk("b2b_r20", 32'(rf[20]), 32'h11);
        chk("b2b_r21", 32'(rf[21]), 32'h22);
        chk("b2b_r22", 32'(rf[22]), 32'h33);

        // Reset landing in EXEC of LDI r7,0xAA must kill the write.
        preload(5'd7, 8'h13);
        w0 = wr_cnt; d0 = done_cnt;
        @(negedge clk);
        instr = {4'h7, 5'd7, 5'd0, 5'd0, 8'hAA}; instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_ready", 32'(instr_ready), 32'd1);
        chk("abort_ctrl",  32'(ctrl),        32'd0);
        chk("abort_flags", 32'({done, zero, carry, illegal}), 32'd0);
        chk("abort_Wdata", 32'(Wdata),       32'd0);
        chk("abort_Rd",    32'(Rd),          32'd0);
        repeat (3) @(negedge clk);
        chk("abort_r7",     32'(rf[7]),          32'h13);
        chk("abort_writes", 32'(wr_cnt - w0),    32'd0);
        chk("abort_done",   32'(done_cnt - d0),  32'd0);
        chk("abort_idle",   32'(instr_ready),    32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
